vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/axis_counter.sv | 32 +++
 rtl/vga_timing_gen.sv | 84 ++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter width and small helpers
// for the VGA timing generator.
package vga_timing_pkg;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned CNT_LIMIT = 65535;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   // True when pos lies in [lo, lo+len-1]; the compare is done zero-extended.
   function automatic logic in_span(input cnt_t pos, input int unsigned lo,
                                    input int unsigned len);
      logic [31:0] p;
      p = 32'(pos);
      return (p >= lo) && (p < lo + len);
   endfunction

endpackage

// File: rtl/axis_counter.sv
// Wrap-enabled modulo counter (0..MAX) with terminal-count and next-value
// outputs; resets to MAX so the first enabled step lands on 0.
module axis_counter
   import vga_timing_pkg::*;
#(
   parameter cnt_t MAX = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output cnt_t count,
   output cnt_t next,
   output logic tc
);

   always_comb begin
      tc   = (count == MAX);
      next = count;
      if (en) begin
         next = tc ? '0 : count + cnt_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= MAX;
      end else begin
         count <= next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical position counters with
// registered sync, blanking and line/frame strobes aligned to the counters.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0
) (
   input  logic        clk_25MHz,
   input  logic        rst,
   input  logic        pix_en,
   output logic [15:0] H_count_Value,
   output logic [15:0] V_count_Value,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_end,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 16-bit counter range");
   end

   localparam cnt_t H_MAX = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_MAX = cnt_t'(V_TOTAL - 1);

   cnt_t h_next;
   cnt_t v_next;
   logic h_tc;
   logic v_tc;
   logic v_en;

   assign v_en = pix_en & h_tc;

   axis_counter #(.MAX(H_MAX)) u_h_cnt (
      .clk   (clk_25MHz),
      .rst   (rst),
      .en    (pix_en),
      .count (H_count_Value),
      .next  (h_next),
      .tc    (h_tc)
   );

   axis_counter #(.MAX(V_MAX)) u_v_cnt (
      .clk   (clk_25MHz),
      .rst   (rst),
      .en    (v_en),
      .count (V_count_Value),
      .next  (v_next),
      .tc    (v_tc)
   );

   // Outputs are decoded from the next-count values so they land on the same
   // edge as the counters; with pix_en low next equals current, so levels hold.
   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         video_on    <= 1'b0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= in_span(h_next, H_ACTIVE + H_FP, H_SYNC) ? H_POL : ~H_POL;
         vsync       <= in_span(v_next, V_ACTIVE + V_FP, V_SYNC) ? V_POL : ~V_POL;
         video_on    <= (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
         line_end    <= pix_en && (h_next == H_MAX);
         // Both counters at terminal count with enable is the only way into (0,0).
         frame_start <= pix_en && h_tc && v_tc;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing and reduced-timing instances
// checked every cycle against a frame-position model plus literal pins.
module tb_vga_timing_gen;

   localparam int unsigned HA[2] = '{640, 8};
   localparam int unsigned HF[2] = '{16, 2};
   localparam int unsigned HS[2] = '{96, 2};
   localparam int unsigned HB[2] = '{48, 2};
   localparam int unsigned VA[2] = '{480, 4};
   localparam int unsigned VF[2] = '{10, 1};
   localparam int unsigned VS[2] = '{2, 1};
   localparam int unsigned VB[2] = '{33, 1};
   localparam bit          HP[2] = '{1'b0, 1'b1};
   localparam bit          VP[2] = '{1'b0, 1'b0};

   logic        clk_25MHz = 1'b0;
   logic        rst       = 1'b1;
   logic        pix_en    = 1'b0;
   logic [15:0] h_o[2];
   logic [15:0] v_o[2];
   logic        hs_o[2], vs_o[2], vo_o[2], le_o[2], fs_o[2];

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned le_cnt = 0;

   // Model state: linear position within the frame and the sampled enable.
   int unsigned pos[2];
   bit          en_q[2];

   // Stats for the reduced-timing instance.
   int unsigned fs_first, fs_last, fs_n, vo_n, hmax, vmax;
   logic [31:0] hs_mask, vs_mask;

   vga_timing_gen dut0 (
      .clk_25MHz     (clk_25MHz),
      .rst           (rst),
      .pix_en        (pix_en),
      .H_count_Value (h_o[0]),
      .V_count_Value (v_o[0]),
      .hsync         (hs_o[0]),
      .vsync         (vs_o[0]),
      .video_on      (vo_o[0]),
      .line_end      (le_o[0]),
      .frame_start   (fs_o[0])
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .H_POL    (1'b1)
   ) dut1 (
      .clk_25MHz     (clk_25MHz),
      .rst           (rst),
      .pix_en        (pix_en),
      .H_count_Value (h_o[1]),
      .V_count_Value (v_o[1]),
      .hsync         (hs_o[1]),
      .vsync         (vs_o[1]),
      .video_on      (vo_o[1]),
      .line_end      (le_o[1]),
      .frame_start   (fs_o[1])
   );

   always #20 clk_25MHz = ~clk_25MHz;

   function automatic int unsigned htot(input int d);
      return HA[d] + HF[d] + HS[d] + HB[d];
   endfunction

   function automatic int unsigned vtot(input int d);
      return VA[d] + VF[d] + VS[d] + VB[d];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk_25MHz or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            pos[d]  = htot(d) * vtot(d) - 1;
            en_q[d] = 1'b0;
         end else begin
            en_q[d] = pix_en;
            if (pix_en) pos[d] = (pos[d] + 1) % (htot(d) * vtot(d));
         end
      end
   end

   always @(negedge clk_25MHz) begin
      for (int d = 0; d < 2; d++) begin
         int unsigned h, v;
         bit ehs, evs;
         h   = pos[d] % htot(d);
         v   = pos[d] / htot(d);
         ehs = (h >= HA[d] + HF[d] && h < HA[d] + HF[d] + HS[d]) ? HP[d] : !HP[d];
         evs = (v >= VA[d] + VF[d] && v < VA[d] + VF[d] + VS[d]) ? VP[d] : !VP[d];
         chk($sformatf("dut%0d H", d), 32'(h_o[d]), h);
         chk($sformatf("dut%0d V", d), 32'(v_o[d]), v);
         chk($sformatf("dut%0d hsync", d), 32'(hs_o[d]), 32'(ehs));
         chk($sformatf("dut%0d vsync", d), 32'(vs_o[d]), 32'(evs));
         chk($sformatf("dut%0d video_on", d), 32'(vo_o[d]), 32'(h < HA[d] && v < VA[d]));
         chk($sformatf("dut%0d line_end", d), 32'(le_o[d]), 32'(en_q[d] && h == htot(d) - 1));
         chk($sformatf("dut%0d frame_start", d), 32'(fs_o[d]), 32'(en_q[d] && pos[d] == 0));
      end
      if (le_o[0] === 1'b1) le_cnt++;
   end

   task automatic cyc(input logic en);
      pix_en = en;
      @(posedge clk_25MHz);
      #10;
   endtask

   task automatic run(input int unsigned n);
      repeat (n) cyc(1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " H0"}, 32'(h_o[0]), 799);
      chk({tag, " V0"}, 32'(v_o[0]), 524);
      chk({tag, " hsync0"}, 32'(hs_o[0]), 1);
      chk({tag, " vsync0"}, 32'(vs_o[0]), 1);
      chk({tag, " video_on0"}, 32'(vo_o[0]), 0);
      chk({tag, " line_end0"}, 32'(le_o[0]), 0);
      chk({tag, " frame_start0"}, 32'(fs_o[0]), 0);
      chk({tag, " H1"}, 32'(h_o[1]), 13);
      chk({tag, " V1"}, 32'(v_o[1]), 6);
      chk({tag, " hsync1"}, 32'(hs_o[1]), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      pix_en = 1'b0;
      repeat (3) @(posedge clk_25MHz);
      #10;
      chk_reset_vals("reset");

      rst = 1'b0;
      cyc(1'b1);
      chk("first H", 32'(h_o[0]), 0);
      chk("first V", 32'(v_o[0]), 0);
      chk("first frame_start", 32'(fs_o[0]), 1);
      chk("first video_on", 32'(vo_o[0]), 1);
      chk("first hsync", 32'(hs_o[0]), 1);
      chk("first vsync", 32'(vs_o[0]), 1);

      run(655);
      chk("H655", 32'(h_o[0]), 655);
      chk("hsync@655", 32'(hs_o[0]), 1);
      cyc(1'b1);
      chk("hsync@656", 32'(hs_o[0]), 0);
      run(95);
      chk("H751", 32'(h_o[0]), 751);
      chk("hsync@751", 32'(hs_o[0]), 0);
      cyc(1'b1);
      chk("hsync@752", 32'(hs_o[0]), 1);
      run(46);
      chk("line_end@798", 32'(le_o[0]), 0);
      cyc(1'b1);
      chk("line_end@799", 32'(le_o[0]), 1);
      chk("V@799", 32'(v_o[0]), 0);
      cyc(1'b1);
      chk("wrap H", 32'(h_o[0]), 0);
      chk("wrap V", 32'(v_o[0]), 1);
      chk("wrap line_end", 32'(le_o[0]), 0);

      // Enable gap straddling the end of line 1.
      run(798);
      cyc(1'b1);
      chk("gap le@799", 32'(le_o[0]), 1);
      cyc(1'b0);
      chk("gap hold H a", 32'(h_o[0]), 799);
      chk("gap hold V a", 32'(v_o[0]), 1);
      chk("gap le a", 32'(le_o[0]), 0);
      cyc(1'b0);
      chk("gap hold H b", 32'(h_o[0]), 799);
      chk("gap le b", 32'(le_o[0]), 0);
      cyc(1'b1);
      chk("gap resume H", 32'(h_o[0]), 0);
      chk("gap resume V", 32'(v_o[0]), 2);
      chk("line_end pulses", le_cnt, 2);

      // Mid-frame reset at (300,3).
      run(1100);
      chk("pre-reset H", 32'(h_o[0]), 300);
      chk("pre-reset V", 32'(v_o[0]), 3);
      rst = 1'b1;
      #1;
      chk_reset_vals("midreset");
      cyc(1'b1);
      cyc(1'b1);
      chk("held reset H", 32'(h_o[0]), 799);
      chk("held reset fs", 32'(fs_o[0]), 0);
      rst = 1'b0;
      cyc(1'b1);
      chk("restart H", 32'(h_o[0]), 0);
      chk("restart V", 32'(v_o[0]), 0);
      chk("restart fs0", 32'(fs_o[0]), 1);
      chk("restart fs1", 32'(fs_o[1]), 1);

      // Two full frames of the reduced-timing instance.
      fs_first = 0; fs_last = 0; fs_n = 0; vo_n = 0; hmax = 0; vmax = 0;
      hs_mask = '0; vs_mask = '0;
      for (int unsigned i = 1; i <= 196; i++) begin
         cyc(1'b1);
         if (fs_o[1] === 1'b1) begin
            if (fs_n == 0) fs_first = i;
            fs_last = i;
            fs_n++;
         end
         if (i <= 98) begin
            if (vo_o[1] === 1'b1) vo_n++;
            if (hs_o[1] === 1'b1) hs_mask = hs_mask | (32'd1 << h_o[1]);
            if (vs_o[1] === 1'b0) vs_mask = vs_mask | (32'd1 << v_o[1]);
            if (32'(h_o[1]) > hmax) hmax = 32'(h_o[1]);
            if (32'(v_o[1]) > vmax) vmax = 32'(v_o[1]);
         end
      end
      chk("small first fs", fs_first, 98);
      chk("small fs period", fs_last - fs_first, 98);
      chk("small fs count", fs_n, 2);
      chk("small video_on count", vo_n, 32);
      chk("small hsync H set", hs_mask, 32'h0000_0C00);
      chk("small vsync V set", vs_mask, 32'h0000_0020);
      chk("small H max", hmax, 13);
      chk("small V max", vmax, 6);

      for (int unsigned i = 0; i < 120; i++) begin
         cyc((i % 3) != 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
